psum_acc_mg: RTL and testbench

Generalised partial-sum accumulator between the MAC array and map_merger. It accumulates NGRP input-channel-group passes (not just two) per output address in an on-chip psum buffer, over NLANE parametrised lanes with optional saturation. Results are emitted on the last pass through a 2-entry output queue with full backpressure. A forwarding path removes the read-after-write hazard for back-to-back accesses to the same address.

---
 rtl/psum_acc_pkg.sv | 35 +++
 rtl/psum_acc_oq.sv | 69 ++++++
 rtl/sirv_gnrl_dfflr.sv | 20 ++
 rtl/sirv_sim_ram.sv | 33 +++
 rtl/psum_acc_mg.sv | 116 +++++++++++
 tb/tb_psum_acc_mg.sv | 309 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/psum_acc_pkg.sv
// Shared constants and lane arithmetic for the partial-sum accumulator.
package psum_acc_pkg;

    // Info field offsets; flag bits sit directly above the AW-bit address.
    localparam int unsigned ADDR_LSB  = 0;
    localparam int unsigned FIRST_OFS = 0;
    localparam int unsigned LAST_OFS  = 1;
    localparam int unsigned TSEL_OFS  = 2;

    function automatic logic signed [63:0] lane_max(input int unsigned lw);
        return (64'sd1 <<< (lw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] lane_min(input int unsigned lw);
        return -(64'sd1 <<< (lw - 1));
    endfunction

    // Operands arrive sign-extended; the caller truncates to lw bits, which wraps when sat=0.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int unsigned        lw,
                                                   input logic               sat);
        logic signed [63:0] s;
        s = a + b;
        if (sat) begin
            if (s > lane_max(lw)) begin
                s = lane_max(lw);
            end else if (s < lane_min(lw)) begin
                s = lane_min(lw);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/psum_acc_oq.sv
// Two-entry output FIFO; entry 0 is always the head and count is exposed for flow control.
module psum_acc_oq #(
    parameter int unsigned DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_din,
    input  logic          i_pop,
    output logic [DW-1:0] o_dout,
    output logic          o_vld,
    output logic [1:0]    o_cnt
);

    logic [1:0]    r_cnt;
    logic [1:0]    w_cnt_nxt;
    logic [DW-1:0] r_e0;
    logic [DW-1:0] r_e1;
    logic [DW-1:0] w_e0_nxt;
    logic          w_e0_en;
    logic          w_e1_en;
    logic          w_pop;

    assign w_pop = i_pop & (r_cnt != 2'd0);

    always_comb begin
        w_cnt_nxt = r_cnt + {1'b0, i_push} - {1'b0, w_pop};
        w_e0_nxt  = i_din;
        w_e0_en   = 1'b0;
        w_e1_en   = 1'b0;
        if (w_pop) begin
            w_e0_en  = 1'b1;
            w_e0_nxt = (i_push && r_cnt == 2'd1) ? i_din : r_e1;
            w_e1_en  = i_push && r_cnt == 2'd2;
        end else if (i_push) begin
            w_e0_en = (r_cnt == 2'd0);
            w_e1_en = (r_cnt != 2'd0);
        end
    end

    sirv_gnrl_dfflr #(.DW(2)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_lden (i_push | w_pop),
        .i_dnxt (w_cnt_nxt),
        .o_qout (r_cnt)
    );

    sirv_gnrl_dfflr #(.DW(DW)) u_e0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_lden (w_e0_en),
        .i_dnxt (w_e0_nxt),
        .o_qout (r_e0)
    );

    sirv_gnrl_dfflr #(.DW(DW)) u_e1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_lden (w_e1_en),
        .i_dnxt (i_din),
        .o_qout (r_e1)
    );

    assign o_dout = r_e0;
    assign o_vld  = (r_cnt != 2'd0);
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/sirv_gnrl_dfflr.sv
// Load-enabled register with synchronous active-low reset to zero.
module sirv_gnrl_dfflr #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_lden,
    input  logic [DW-1:0] i_dnxt,
    output logic [DW-1:0] o_qout
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_qout <= '0;
        end else if (i_lden) begin
            o_qout <= i_dnxt;
        end
    end

endmodule

// File: rtl/sirv_sim_ram.sv
// Simple 1W1R RAM with byte write mask and 1-cycle registered read (read-before-write).
module sirv_sim_ram #(
    parameter int unsigned DP = 4096,
    parameter int unsigned DW = 64,
    parameter int unsigned MW = 8,
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_din,
    input  logic [MW-1:0] i_wem,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_dout
);

    logic [DW-1:0] r_mem [DP];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < int'(MW); i++) begin
                if (i_wem[i]) begin
                    r_mem[i_waddr][i*8 +: 8] <= i_din[i*8 +: 8];
                end
            end
        end
        if (i_re) begin
            o_dout <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/psum_acc_mg.sv
// Multi-group partial-sum accumulator: SRAM-backed per-address sums, forwarding for
// back-to-back same-address beats, results of last passes emitted through a 2-entry queue.
module psum_acc_mg
    import psum_acc_pkg::*;
#(
    parameter int unsigned AW    = 12,
    parameter int unsigned NLANE = 2,
    parameter int unsigned LW    = 28,
    parameter int unsigned TW    = 8,
    parameter int unsigned DW    = NLANE * LW + TW,
    parameter bit          SAT   = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   mac_array2psum_acc_info,
    input  logic [DW-1:0] mac_array2psum_acc_data,
    input  logic          mac_array2psum_acc_vld,
    output logic          mac_array2psum_acc_rdy,
    output logic [DW-1:0] psum_acc2map_merger_data,
    output logic          psum_acc2map_merger_vld,
    input  logic          psum_acc2map_merger_rdy
);

    localparam int unsigned FIRST_BIT = AW + FIRST_OFS;
    localparam int unsigned LAST_BIT  = AW + LAST_OFS;
    localparam int unsigned TSEL_BIT  = AW + TSEL_OFS;
    localparam int unsigned MW        = DW / 8;

    logic          w_acc;
    logic [1:0]    w_cnt;
    logic [DW-1:0] w_ram_dout;
    logic [DW-1:0] w_oper;
    logic [DW-1:0] w_sum;
    logic          w_fwd_hit;
    logic          w_unused_info;

    logic          r_s1_vld;
    logic [AW-1:0] r_s1_addr;
    logic          r_s1_first;
    logic          r_s1_last;
    logic          r_s1_tsel;
    logic [DW-1:0] r_s1_data;
    logic          r_fwd_vld;
    logic [AW-1:0] r_fwd_addr;
    logic [DW-1:0] r_fwd_data;

    assign w_unused_info = ^mac_array2psum_acc_info[31:TSEL_BIT+1];

    // Reserve a queue slot for every last beat already in S1.
    assign mac_array2psum_acc_rdy =
        ({1'b0, w_cnt} + {2'b00, r_s1_vld & r_s1_last}) < 3'd2;
    assign w_acc = mac_array2psum_acc_vld & mac_array2psum_acc_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_fwd_vld <= 1'b0;
        end else begin
            r_s1_vld  <= w_acc;
            r_fwd_vld <= r_s1_vld & ~r_s1_last;
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_s1_addr  <= mac_array2psum_acc_info[ADDR_LSB +: AW];
            r_s1_first <= mac_array2psum_acc_info[FIRST_BIT];
            r_s1_last  <= mac_array2psum_acc_info[LAST_BIT];
            r_s1_tsel  <= mac_array2psum_acc_info[TSEL_BIT];
            r_s1_data  <= mac_array2psum_acc_data;
        end
        r_fwd_addr <= r_s1_addr;
        r_fwd_data <= w_sum;
    end

    sirv_sim_ram #(.DP(2**AW), .DW(DW), .MW(MW), .AW(AW)) u_buf (
        .clk     (clk),
        .i_we    (r_s1_vld & ~r_s1_last),
        .i_waddr (r_s1_addr),
        .i_din   (w_sum),
        .i_wem   ({MW{1'b1}}),
        .i_re    (w_acc & ~mac_array2psum_acc_info[FIRST_BIT]),
        .i_raddr (mac_array2psum_acc_info[ADDR_LSB +: AW]),
        .o_dout  (w_ram_dout)
    );

    // The SRAM read for this beat overlapped the previous beat's write, so it is stale.
    assign w_fwd_hit = r_fwd_vld & (r_fwd_addr == r_s1_addr);
    assign w_oper    = w_fwd_hit ? r_fwd_data : w_ram_dout;

    always_comb begin
        w_sum = r_s1_data;
        if (!r_s1_first) begin
            for (int i = 0; i < int'(NLANE); i++) begin
                w_sum[i*LW +: LW] = LW'(sat_add(64'(signed'(w_oper[i*LW +: LW])),
                                                64'(signed'(r_s1_data[i*LW +: LW])),
                                                LW, SAT));
            end
            if (!r_s1_tsel) begin
                w_sum[DW-1 -: TW] = w_oper[DW-1 -: TW];
            end
        end
    end

    psum_acc_oq #(.DW(DW)) u_oq (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (r_s1_vld & r_s1_last),
        .i_din  (w_sum),
        .i_pop  (psum_acc2map_merger_vld & psum_acc2map_merger_rdy),
        .o_dout (psum_acc2map_merger_data),
        .o_vld  (psum_acc2map_merger_vld),
        .o_cnt  (w_cnt)
    );

endmodule

// File: tb/tb_psum_acc_mg.sv
// Bench for psum_acc_mg: directed vector table, backpressure/reset sequences, random scoreboard.
module tb_psum_acc_mg;
    localparam int unsigned AW = 12, NLANE = 2, LW = 28, TW = 8, DW = 64;
    localparam longint HALF = 64'sd1 <<< (LW - 1);
    localparam longint FULL = 64'sd1 <<< LW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]   info;
    logic [DW-1:0] din;
    logic          vld;
    logic          ordy;
    logic          rdy_s, rdy_w, ovld_s, ovld_w;
    logic [DW-1:0] odat_s, odat_w;

    psum_acc_mg #(.AW(AW), .NLANE(NLANE), .LW(LW), .TW(TW), .DW(DW), .SAT(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .mac_array2psum_acc_info(info), .mac_array2psum_acc_data(din),
        .mac_array2psum_acc_vld(vld), .mac_array2psum_acc_rdy(rdy_s),
        .psum_acc2map_merger_data(odat_s), .psum_acc2map_merger_vld(ovld_s),
        .psum_acc2map_merger_rdy(ordy)
    );

    psum_acc_mg #(.AW(AW), .NLANE(NLANE), .LW(LW), .TW(TW), .DW(DW), .SAT(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .mac_array2psum_acc_info(info), .mac_array2psum_acc_data(din),
        .mac_array2psum_acc_vld(vld), .mac_array2psum_acc_rdy(rdy_w),
        .psum_acc2map_merger_data(odat_w), .psum_acc2map_merger_vld(ovld_w),
        .psum_acc2map_merger_rdy(ordy)
    );

    int checks = 0;
    int errors = 0;
    int n_out = 0;
    bit rnd_ordy = 1'b0;
    logic [DW-1:0] mem_s [int];
    logic [DW-1:0] mem_w [int];
    logic [DW-1:0] exp_s [$];
    logic [DW-1:0] exp_w [$];
    bit started [4];

    typedef struct {
        logic [AW-1:0] addr;
        bit            first, last, tsel;
        logic [DW-1:0] data;
        logic [DW-1:0] exp_s, exp_w;
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: per-lane signed add on plain integers, clamped or wrapped.
    function automatic logic [DW-1:0] model(input logic [DW-1:0] oper, input logic [DW-1:0] d,
                                            input bit first, input bit tsel, input bit sat);
        logic [DW-1:0] r;
        longint a, b, s;
        if (first) return d;
        r = '0;
        for (int i = 0; i < int'(NLANE); i++) begin
            a = longint'(oper[i*LW +: LW]);
            b = longint'(d[i*LW +: LW]);
            if (a >= HALF) a -= FULL;
            if (b >= HALF) b -= FULL;
            s = a + b;
            if (sat && s > HALF - 1) s = HALF - 1;
            if (sat && s < -HALF) s = -HALF;
            r[i*LW +: LW] = s[LW-1:0];
        end
        r[DW-1 -: TW] = tsel ? d[DW-1 -: TW] : oper[DW-1 -: TW];
        return r;
    endfunction

    task automatic model_accept(input int addr, input bit first, input bit last,
                                input bit tsel, input logic [DW-1:0] d);
        logic [DW-1:0] os, ow, rs, rw;
        os = mem_s.exists(addr) ? mem_s[addr] : '0;
        ow = mem_w.exists(addr) ? mem_w[addr] : '0;
        rs = model(os, d, first, tsel, 1'b1);
        rw = model(ow, d, first, tsel, 1'b0);
        if (last) begin
            exp_s.push_back(rs);
            exp_w.push_back(rw);
        end else begin
            mem_s[addr] = rs;
            mem_w[addr] = rw;
        end
    endtask

    task automatic set_in(input logic [AW-1:0] addr, input bit first, input bit last,
                          input bit tsel, input logic [DW-1:0] d);
        info = $urandom();
        info[AW+2:0] = {tsel, last, first, addr};
        din = d;
        vld = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_beat(input logic [AW-1:0] addr, input bit first, input bit last,
                             input bit tsel, input logic [DW-1:0] d);
        bit done = 1'b0;
        set_in(addr, first, last, tsel, d);
        for (int c = 0; c < 200 && !done; c++) begin
            if (rnd_ordy) ordy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (rdy_s) begin
                model_accept(int'(addr), first, last, tsel, d);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        vld = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout addr=%0d", addr);
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            if (rnd_ordy) ordy = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
    endtask

    // Output must be absent in the S1 cycle and present in the next one.
    task automatic wait_out(input string name, input logic [DW-1:0] es, input logic [DW-1:0] ew);
        @(negedge clk);
        chk({name, "_early"}, 64'(ovld_s), 64'd0);
        @(negedge clk);
        chk({name, "_vld"}, 64'(ovld_s), 64'd1);
        chk({name, "_sat"}, odat_s, es);
        chk({name, "_wrap"}, odat_w, ew);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int c = 0;
        ordy = 1'b1;
        while ((exp_s.size() != 0 || exp_w.size() != 0) && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk(name, 64'(exp_s.size() + exp_w.size()), 64'd0);
    endtask

    function automatic vec_t mk(input logic [AW-1:0] a, input bit f, input bit l, input bit t,
                                input logic [DW-1:0] d, input logic [DW-1:0] es,
                                input logic [DW-1:0] ew);
        vec_t v;
        v.addr = a; v.first = f; v.last = l; v.tsel = t;
        v.data = d; v.exp_s = es; v.exp_w = ew;
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (ovld_s && ordy) begin
                if (exp_s.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_sat_extra got=%h", odat_s);
                end else begin
                    chk("sb_sat", odat_s, exp_s.pop_front());
                    n_out++;
                end
            end
            if (ovld_w && ordy) begin
                if (exp_w.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_wrap_extra got=%h", odat_w);
                end else begin
                    chk("sb_wrap", odat_w, exp_w.pop_front());
                end
            end
        end
    end

    initial begin
        int n0, nlast;
        logic [DW-1:0] d;
        vld = 1'b0; info = '0; din = '0; ordy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_vld_s", 64'(ovld_s), 64'd0);
        chk("reset_vld_w", 64'(ovld_w), 64'd0);
        chk("reset_rdy", 64'(rdy_s), 64'd1);
        @(posedge clk);
        #1;

        // {tag, lane1, lane0}
        tbl.push_back(mk(12'd5, 1, 0, 0, {8'h11, 28'd1, 28'd10}, '0, '0));
        tbl.push_back(mk(12'd5, 0, 0, 0, {8'h12, 28'd2, 28'd20}, '0, '0));
        tbl.push_back(mk(12'd5, 0, 1, 0, {8'h13, 28'd3, 28'hFFFFFF9},
                         {8'h11, 28'd6, 28'd23}, {8'h11, 28'd6, 28'd23}));
        tbl.push_back(mk(12'd9, 1, 0, 0, {8'h22, 28'd0, 28'd1}, '0, '0));
        tbl.push_back(mk(12'd9, 0, 0, 0, {8'h23, 28'd0, 28'd2}, '0, '0));
        tbl.push_back(mk(12'd9, 0, 1, 0, {8'h24, 28'd0, 28'd3},
                         {8'h22, 28'd0, 28'd6}, {8'h22, 28'd0, 28'd6}));
        tbl.push_back(mk(12'd7, 1, 0, 0, {8'h33, 28'h8000000, 28'h7FFFFF0}, '0, '0));
        tbl.push_back(mk(12'd7, 0, 1, 0, {8'h44, 28'hFFFFFFF, 28'h0000020},
                         {8'h33, 28'h8000000, 28'h7FFFFFF}, {8'h33, 28'h7FFFFFF, 28'h8000010}));
        tbl.push_back(mk(12'd3, 1, 0, 0, {8'hA5, 28'd200, 28'd100}, '0, '0));
        tbl.push_back(mk(12'd3, 0, 1, 0, {8'h3C, 28'd6, 28'd5},
                         {8'hA5, 28'd206, 28'd105}, {8'hA5, 28'd206, 28'd105}));
        tbl.push_back(mk(12'd4, 1, 0, 0, {8'hA5, 28'd200, 28'd100}, '0, '0));
        tbl.push_back(mk(12'd4, 0, 1, 1, {8'h3C, 28'd6, 28'd5},
                         {8'h3C, 28'd206, 28'd105}, {8'h3C, 28'd206, 28'd105}));
        tbl.push_back(mk(12'd100, 1, 1, 0, {8'h77, 28'h1234567, 28'hFFFFFFB},
                         {8'h77, 28'h1234567, 28'hFFFFFFB}, {8'h77, 28'h1234567, 28'hFFFFFFB}));

        n0 = n_out;
        nlast = 0;
        foreach (tbl[i]) begin
            send_beat(tbl[i].addr, tbl[i].first, tbl[i].last, tbl[i].tsel, tbl[i].data);
            if (tbl[i].last) begin
                nlast++;
                wait_out($sformatf("vec%0d", i), tbl[i].exp_s, tbl[i].exp_w);
            end
        end
        idle(2);
        chk("vec_out_count", 64'(n_out - n0), 64'(nlast));

        // Backpressure: two queued with nothing in flight must block the input.
        ordy = 1'b0;
        n0 = n_out;
        send_beat(12'd200, 1, 1, 0, {8'h01, 28'd11, 28'd1});
        send_beat(12'd201, 1, 1, 0, {8'h02, 28'd22, 28'd2});
        set_in(12'd202, 1, 1, 0, {8'h03, 28'd33, 28'd3});
        @(negedge clk);
        chk("bp_rdy_inflight", 64'(rdy_s), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_rdy_full", 64'(rdy_s), 64'd0);
        chk("bp_head", odat_s, {8'h01, 28'd11, 28'd1});
        @(posedge clk);
        #1;
        vld = 1'b0;
        ordy = 1'b1;
        send_beat(12'd202, 1, 1, 0, {8'h03, 28'd33, 28'd3});
        send_beat(12'd203, 1, 1, 0, {8'h04, 28'd44, 28'd4});
        drain("bp_drain");
        idle(2);
        chk("bp_out_count", 64'(n_out - n0), 64'd4);

        // Reset with one entry queued and a last beat sitting in S1.
        ordy = 1'b0;
        send_beat(12'd300, 1, 0, 0, {8'h05, 28'd0, 28'd50});
        send_beat(12'd301, 1, 1, 0, {8'h06, 28'd0, 28'd60});
        send_beat(12'd300, 0, 1, 0, {8'h07, 28'd0, 28'd70});
        chk("pre_rst_vld", 64'(ovld_s), 64'd1);
        rst_n = 1'b0;
        exp_s.delete();
        exp_w.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_vld_s", 64'(ovld_s), 64'd0);
        chk("rst_vld_w", 64'(ovld_w), 64'd0);
        chk("rst_rdy", 64'(rdy_s), 64'd1);
        @(posedge clk);
        #1;
        ordy = 1'b1;
        idle(3);
        send_beat(12'd300, 1, 0, 0, {8'h08, 28'd3, 28'd5});
        send_beat(12'd300, 0, 1, 1, {8'h09, 28'd4, 28'd6});
        wait_out("post_rst", {8'h09, 28'd7, 28'd11}, {8'h09, 28'd7, 28'd11});

        // Random groups over four addresses with random output backpressure.
        rnd_ordy = 1'b1;
        foreach (started[i]) started[i] = 1'b0;
        for (int k = 0; k < 400; k++) begin
            int a;
            bit f, l;
            a = $urandom_range(0, 3);
            f = !started[a] || ($urandom_range(0, 7) == 0);
            l = ($urandom_range(0, 2) == 0);
            d = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) d[LW-1:0] = 28'h7FFFF00 | 28'($urandom_range(0, 255));
            send_beat(12'(a + 16), f, l, 1'($urandom_range(0, 1)), d);
            started[a] = !l;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rnd_ordy = 1'b0;
        drain("rand_drain");
        idle(2);
        chk("final_vld", 64'(ovld_s), 64'd0);
        chk("final_rdy", 64'(rdy_s), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
